// File: rtl/melody_sequencer.sv
// Four-note melody player for the Simon LED/speaker path, with live button echo
// granted only while no melody is playing.
module melody_sequencer #(
    parameter int NOTE_TICKS = 12500000,
    parameter int GAP_TICKS  = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] melody_sel,
    input  logic       abort,
    input  logic       echo_req,
    input  logic [1:0] echo_color,
    output logic [1:0] color,
    output logic       led_enable,
    output logic       spkr_en,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_TICKS > 0) ? 32'(GAP_TICKS - 1) : 32'd0;
    localparam bit          HAS_GAP   = (GAP_TICKS > 0);

    state_t      state;
    logic [31:0] tick;
    logic [1:0]  idx;
    logic [1:0]  sel_q;

    // Each melody row packs note 0 in the low bits.
    function automatic logic [1:0] note_of(input logic [1:0] sel, input logic [1:0] n);
        logic [7:0] row;
        case (sel)
            2'd0:    row = {2'd3, 2'd2, 2'd1, 2'd0};
            2'd1:    row = {2'd3, 2'd1, 2'd2, 2'd0};
            2'd2:    row = {2'd0, 2'd1, 2'd2, 2'd3};
            default: row = {2'd3, 2'd3, 2'd3, 2'd3};
        endcase
        return row[{n, 1'b0} +: 2];
    endfunction

    assign spkr_en = led_enable;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state      <= IDLE;
            tick       <= 32'd0;
            idx        <= 2'd0;
            sel_q      <= 2'd0;
            color      <= 2'd0;
            led_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tick <= 32'd0;
                    idx  <= 2'd0;
                    if (start) begin
                        state      <= NOTE;
                        sel_q      <= melody_sel;
                        busy       <= 1'b1;
                        led_enable <= 1'b1;
                        color      <= note_of(melody_sel, 2'd0);
                    end else if (echo_req) begin
                        led_enable <= 1'b1;
                        color      <= echo_color;
                    end else begin
                        led_enable <= 1'b0;
                        color      <= 2'd0;
                    end
                end
                NOTE: begin
                    if (tick == NOTE_LAST) begin
                        tick <= 32'd0;
                        if (idx == 2'd3) begin
                            state      <= IDLE;
                            idx        <= 2'd0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            led_enable <= 1'b0;
                            color      <= 2'd0;
                        end else if (HAS_GAP) begin
                            state      <= GAP;
                            led_enable <= 1'b0;
                            color      <= 2'd0;
                        end else begin
                            idx   <= idx + 2'd1;
                            color <= note_of(sel_q, idx + 2'd1);
                        end
                    end else begin
                        tick <= tick + 32'd1;
                    end
                end
                GAP: begin
                    // The note index advances as the next note lights up.
                    if (tick == GAP_LAST) begin
                        state      <= NOTE;
                        tick       <= 32'd0;
                        idx        <= idx + 2'd1;
                        led_enable <= 1'b1;
                        color      <= note_of(sel_q, idx + 2'd1);
                    end else begin
                        tick <= tick + 32'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    led_enable <= 1'b0;
                    color      <= 2'd0;
                end
            endcase
        end
    end

endmodule
